alu: RTL and testbench
======================

Name: alu

Overview:
8-bit arithmetic/logic unit for the 7-step CPU datapath (Scott "But How Do It Know?" machine).
- Computes one of eight operations on A/B with carry-in.
- Produces a result byte plus carry-out, a_larger, equal and zero flags.
- Inputs are sampled and all outputs are registered on the rising clock edge, so results feed the flags register and the bus without combinational paths.

Parameters:
WIDTH, 8, data width of A, B and C. All opcode semantics below are written for 8 and must generalise by width.

Ports:
- clk  input  1  system clock; rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- c_in  input  1  carry-in for ADD/RSH/LSH
- op  input  3  operation select
- C  output  WIDTH  registered result
- c_out  output  1  registered carry/shift-out
- a_larger  output  1  registered flag, unsigned A > B
- equal  output  1  registered flag, A == B
- zero  output  1  registered flag, C result == 0

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n). Asserting reset_n low immediately clears C, c_out, a_larger, equal and zero to 0, independent of clk.
- While reset_n is low, outputs hold 0. The first capture is on the first rising clk edge after release.
- Latency: 1 cycle. Inputs present before rising edge N appear on the outputs after edge N. No enable; a capture happens every cycle.
- No handshake. Inputs may change every cycle.
- Opcode map (octal):
  - 0 ADD: {c_out,C} = A + B + c_in (WIDTH+1-bit sum).
  - 1 RSH: C = {c_in, A[7:1]}; c_out = A[0].
  - 2 LSH: C = {A[6:0], c_in}; c_out = A[7].
  - 3 DEC: C = A - 1, wrapping modulo 256; c_out = 1 only when A == 0x00 (borrow), else 0; c_in ignored.
  - 4 AND: C = A & B; c_out = 0.
  - 5 OR: C = A | B; c_out = 0.
  - 6 XOR: C = A ^ B; c_out = 0.
  - 7 CMP: C = A ^ B; c_out = 0.
- B is ignored for RSH/LSH/DEC. c_in is ignored except for ADD/RSH/LSH.
- a_larger = (A > B) unsigned, and equal = (A == B). Both are computed every cycle regardless of op.
- zero = (next C == 0), evaluated on the same-cycle computed result, not the previously registered C.
- Boundary cases:
  - ADD 0xFF + 0x00 + 1 gives C = 0x00, c_out = 1, zero = 1.
  - DEC 0x00 gives C = 0xFF, c_out = 1.
  - CMP with A == B gives C = 0, zero = 1, equal = 1, a_larger = 0.
- Reset asserted mid-operation discards the in-flight result. No X or undefined output is permitted for any op value.

Test Plan:
1. Reset: hold reset_n low with random inputs and toggling clk -> all outputs 0. Assert reset_n asynchronously between edges -> outputs clear immediately.
2. ADD: A = 0xAA, B = 0x55, c_in = 0 -> C = 0xFF, c_out = 0, zero = 0, a_larger = 1, equal = 0. Then c_in = 1 -> C = 0x00, c_out = 1, zero = 1. Each result appears one cycle after its inputs.
3. Shifts:
   - RSH A = 0x0C: c_in = 0 -> 0x06; c_in = 1 -> 0x86.
   - RSH A = 0x81, c_in = 0 -> 0x40, c_out = 1.
   - LSH A = 0x16: c_in = 0 -> 0x2C; c_in = 1 -> 0x2D.
   - LSH A = 0x81, c_in = 0 -> 0x02, c_out = 1.
4. DEC: A = 0xAA -> C = 0xA9, c_out = 0. A = 0x00 -> C = 0xFF, c_out = 1.
5. Logic with A = 0xAA, B = 0x55: AND -> 0x00, zero = 1. OR -> 0xFF. XOR -> 0xFF. c_out = 0 for all three.
6. CMP:
   - A = B = 0xAA -> C = 0x00, equal = 1, zero = 1, a_larger = 0.
   - A = 0xAC, B = 0xAA -> C = 0x06, a_larger = 1, equal = 0, zero = 0.
   - A = 0x01, B = 0xFF -> a_larger = 0, confirming the comparison is unsigned.

Source files
------------

// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if : operand/result bundle for the datapath ALU.
//
//   A, B      operand bytes                       (master -> slave)
//   c_in      carry-in for ADD/RSH/LSH            (master -> slave)
//   op        3-bit operation select              (master -> slave)
//   C         registered result                   (slave -> master)
//   c_out     registered carry / shift-out        (slave -> master)
//   a_larger  registered flag, unsigned A > B     (slave -> master)
//   equal     registered flag, A == B             (slave -> master)
//   zero      registered flag, result == 0        (slave -> master)
// ---------------------------------------------------------------------------
interface alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic [2:0]       op;
  logic [WIDTH-1:0] C;
  logic             c_out;
  logic             a_larger;
  logic             equal;
  logic             zero;

  modport master (
    output A, B, c_in, op,
    input  C, c_out, a_larger, equal, zero
  );

  modport slave (
    input  A, B, c_in, op,
    output C, c_out, a_larger, equal, zero
  );
endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : registered arithmetic/logic unit for the 7-step CPU datapath.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous, active-low reset; clears every output to 0
//   bus      alu_if.slave : A, B, c_in, op in; C, c_out, a_larger,
//            equal, zero out (all outputs registered, 1-cycle latency)
//
// Opcodes (octal): 0 ADD, 1 RSH, 2 LSH, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 CMP.
// ---------------------------------------------------------------------------
module alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic  clk,
  input  logic  reset_n,
  alu_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'o0,
    OP_RSH = 3'o1,
    OP_LSH = 3'o2,
    OP_DEC = 3'o3,
    OP_AND = 3'o4,
    OP_OR  = 3'o5,
    OP_XOR = 3'o6,
    OP_CMP = 3'o7
  } op_e;

  logic [WIDTH-1:0] c_d,        c_q;
  logic             c_out_d,    c_out_q;
  logic             a_larger_d, a_larger_q;
  logic             equal_d,    equal_q;
  logic             zero_d,     zero_q;

  logic [WIDTH:0]   sum;
  op_e              op_sel;

  assign op_sel = op_e'(bus.op);
  assign sum    = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.c_in};

  always_comb begin
    c_d     = '0;
    c_out_d = 1'b0;
    unique case (op_sel)
      OP_ADD: {c_out_d, c_d} = sum;
      OP_RSH: begin
        c_d     = {bus.c_in, bus.A[WIDTH-1:1]};
        c_out_d = bus.A[0];
      end
      OP_LSH: begin
        c_d     = {bus.A[WIDTH-2:0], bus.c_in};
        c_out_d = bus.A[WIDTH-1];
      end
      OP_DEC: begin
        c_d     = bus.A - {{(WIDTH-1){1'b0}}, 1'b1};
        // borrow out of the decrement only when wrapping from zero
        c_out_d = (bus.A == '0);
      end
      OP_AND: c_d = bus.A & bus.B;
      OP_OR:  c_d = bus.A | bus.B;
      OP_XOR: c_d = bus.A ^ bus.B;
      OP_CMP: c_d = bus.A ^ bus.B;
      default: begin
        c_d     = '0;
        c_out_d = 1'b0;
      end
    endcase
    a_larger_d = (bus.A > bus.B);
    equal_d    = (bus.A == bus.B);
    // flag follows the result being captured this edge, not the held one
    zero_d     = (c_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q        <= '0;
      c_out_q    <= 1'b0;
      a_larger_q <= 1'b0;
      equal_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      c_q        <= c_d;
      c_out_q    <= c_out_d;
      a_larger_q <= a_larger_d;
      equal_q    <= equal_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.C        = c_q;
  assign bus.c_out    = c_out_q;
  assign bus.a_larger = a_larger_q;
  assign bus.equal    = equal_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : directed self-checking bench for alu.
// Expected outputs are packed as {C, c_out, a_larger, equal, zero}.
// ---------------------------------------------------------------------------
module tb_alu;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  alu_if #(.WIDTH(8)) bus ();

  alu #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ci;
    logic [11:0] exp;
  } vec_t;

  function automatic logic [11:0] outs();
    return {bus.C, bus.c_out, bus.a_larger, bus.equal, bus.zero};
  endfunction

  // Apply one input set, clock it in, and sit 1 time unit past the edge.
  task automatic drive(input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic ci);
    bus.op = o; bus.A = a; bus.B = b; bus.c_in = ci;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      drive(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      checks++;
      if (outs() !== 12'h000) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i, outs(), 12'h000);
      end
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (outs() !== 12'h000) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", outs(), 12'h000);
    end
  endtask

  task automatic test_add();
    vec_t v[3];
    v[0] = '{3'o0, 8'hAA, 8'h55, 1'b0, {8'hFF, 4'b0100}};
    v[1] = '{3'o0, 8'hAA, 8'h55, 1'b1, {8'h00, 4'b1101}};
    v[2] = '{3'o0, 8'hFF, 8'h00, 1'b1, {8'h00, 4'b1101}};
    drive(v[0].op, v[0].a, v[0].b, v[0].ci);
    checks++;
    if (outs() !== v[0].exp) begin
      failures++;
      $display("FAIL add[0] got=%h exp=%h", outs(), v[0].exp);
    end
    // new inputs must not reach the outputs before the next edge
    bus.c_in = 1'b1;
    #2;
    checks++;
    if (outs() !== v[0].exp) begin
      failures++;
      $display("FAIL add_latency got=%h exp=%h", outs(), v[0].exp);
    end
    for (int unsigned i = 1; i < 3; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].ci);
      checks++;
      if (outs() !== v[i].exp) begin
        failures++;
        $display("FAIL add[%0d] got=%h exp=%h", i, outs(), v[i].exp);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[6];
    v[0] = '{3'o1, 8'h0C, 8'h00, 1'b0, {8'h06, 4'b0100}};
    v[1] = '{3'o1, 8'h0C, 8'h00, 1'b1, {8'h86, 4'b0100}};
    v[2] = '{3'o1, 8'h81, 8'h00, 1'b0, {8'h40, 4'b1100}};
    v[3] = '{3'o2, 8'h16, 8'h00, 1'b0, {8'h2C, 4'b0100}};
    v[4] = '{3'o2, 8'h16, 8'h00, 1'b1, {8'h2D, 4'b0100}};
    v[5] = '{3'o2, 8'h81, 8'h00, 1'b0, {8'h02, 4'b1100}};
    for (int unsigned i = 0; i < 6; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].ci);
      checks++;
      if (outs() !== v[i].exp) begin
        failures++;
        $display("FAIL shift[%0d] got=%h exp=%h", i, outs(), v[i].exp);
      end
    end
  endtask

  task automatic test_dec();
    vec_t v[3];
    v[0] = '{3'o3, 8'hAA, 8'h00, 1'b0, {8'hA9, 4'b0100}};
    v[1] = '{3'o3, 8'hAA, 8'h00, 1'b1, {8'hA9, 4'b0100}};
    v[2] = '{3'o3, 8'h00, 8'h00, 1'b0, {8'hFF, 4'b1010}};
    for (int unsigned i = 0; i < 3; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].ci);
      checks++;
      if (outs() !== v[i].exp) begin
        failures++;
        $display("FAIL dec[%0d] got=%h exp=%h", i, outs(), v[i].exp);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[4];
    v[0] = '{3'o4, 8'hAA, 8'h55, 1'b0, {8'h00, 4'b0101}};
    v[1] = '{3'o5, 8'hAA, 8'h55, 1'b0, {8'hFF, 4'b0100}};
    v[2] = '{3'o6, 8'hAA, 8'h55, 1'b0, {8'hFF, 4'b0100}};
    v[3] = '{3'o4, 8'hAA, 8'h55, 1'b1, {8'h00, 4'b0101}};
    for (int unsigned i = 0; i < 4; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].ci);
      checks++;
      if (outs() !== v[i].exp) begin
        failures++;
        $display("FAIL logic[%0d] got=%h exp=%h", i, outs(), v[i].exp);
      end
    end
  endtask

  task automatic test_cmp();
    vec_t v[3];
    v[0] = '{3'o7, 8'hAA, 8'hAA, 1'b0, {8'h00, 4'b0011}};
    v[1] = '{3'o7, 8'hAC, 8'hAA, 1'b0, {8'h06, 4'b0100}};
    v[2] = '{3'o7, 8'h01, 8'hFF, 1'b0, {8'hFE, 4'b0000}};
    for (int unsigned i = 0; i < 3; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].ci);
      checks++;
      if (outs() !== v[i].exp) begin
        failures++;
        $display("FAIL cmp[%0d] got=%h exp=%h", i, outs(), v[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[5];
    v[0] = '{3'o0, 8'h80, 8'h80, 1'b0, {8'h00, 4'b1011}};
    v[1] = '{3'o1, 8'h01, 8'h02, 1'b1, {8'h80, 4'b1000}};
    v[2] = '{3'o5, 8'h0F, 8'hF0, 1'b1, {8'hFF, 4'b0000}};
    v[3] = '{3'o0, 8'h12, 8'h34, 1'b1, {8'h47, 4'b0000}};
    v[4] = '{3'o6, 8'h3C, 8'h3C, 1'b1, {8'h00, 4'b0011}};
    for (int unsigned i = 0; i < 5; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].ci);
      checks++;
      if (outs() !== v[i].exp) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h exp=%h", i, outs(), v[i].exp);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(3'o0, 8'hAA, 8'h55, 1'b0);
    checks++;
    if (outs() !== {8'hFF, 4'b0100}) begin
      failures++;
      $display("FAIL areset_pre got=%h exp=%h", outs(), {8'hFF, 4'b0100});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 12'h000) begin
      failures++;
      $display("FAIL areset_clear got=%h exp=%h", outs(), 12'h000);
    end
    drive(3'o6, 8'hAA, 8'h55, 1'b0);
    checks++;
    if (outs() !== 12'h000) begin
      failures++;
      $display("FAIL areset_hold got=%h exp=%h", outs(), 12'h000);
    end
    reset_n = 1'b1;
    drive(3'o6, 8'hAA, 8'h55, 1'b0);
    checks++;
    if (outs() !== {8'hFF, 4'b0100}) begin
      failures++;
      $display("FAIL areset_resume got=%h exp=%h", outs(), {8'hFF, 4'b0100});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.op   = 3'o0;
    bus.A    = 8'h00;
    bus.B    = 8'h00;
    bus.c_in = 1'b0;
    #2;
    test_reset();
    test_add();
    test_shift();
    test_dec();
    test_logic();
    test_cmp();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
